// File: rtl/mbc_control_unit.sv
// Timing and control sequencer for the 16-bit basic computer.
// Decodes state, sequence counter, latched opcode and indirect bit into datapath strobes.
module mbc_control_unit #(
    parameter int W   = 16,
    parameter int SCW = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   ir,
    input  logic           ac_zero,
    input  logic           ac_sign,
    input  logic           dr_zero,
    output logic           ar_ld,
    output logic           pc_ld,
    output logic           dr_ld,
    output logic           ac_ld,
    output logic           ir_ld,
    output logic           tr_ld,
    output logic           ar_inc,
    output logic           pc_inc,
    output logic           dr_inc,
    output logic           ac_inc,
    output logic           ac_clr,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic [2:0]     bus_sel,
    output logic [1:0]     alu_op,
    output logic [SCW-1:0] sc,
    output logic           i_ff,
    output logic           halted
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t         state_q;
    logic [SCW-1:0] sc_q, sc_d;
    logic           i_ff_q;
    logic [2:0]     opcode_q;
    logic           halted_q;
    logic           sc_clr;
    logic           halt_req;
    logic           unusedIrBits;

    // Register-reference bits with no defined operation are decoded as NOP.
    assign unusedIrBits = ^{ir[10], ir[8:6], ir[1]};

    assign sc     = sc_q;
    assign i_ff   = i_ff_q;
    assign halted = halted_q;
    assign sc_d   = sc_clr ? '0 : sc_q + SCW'(1);

    always_comb begin
        ar_ld    = 1'b0;
        pc_ld    = 1'b0;
        dr_ld    = 1'b0;
        ac_ld    = 1'b0;
        ir_ld    = 1'b0;
        tr_ld    = 1'b0;
        ar_inc   = 1'b0;
        pc_inc   = 1'b0;
        dr_inc   = 1'b0;
        ac_inc   = 1'b0;
        ac_clr   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        bus_sel  = 3'd0;
        alu_op   = 2'd0;
        sc_clr   = 1'b0;
        halt_req = 1'b0;
        if (reset && state_q == RUN) begin
            case (sc_q)
                SCW'(0): begin bus_sel = 3'd2; ar_ld = 1'b1; end
                SCW'(1): begin bus_sel = 3'd7; mem_rd = 1'b1; ir_ld = 1'b1; pc_inc = 1'b1; end
                SCW'(2): begin bus_sel = 3'd5; ar_ld = 1'b1; end
                SCW'(3): begin
                    if (opcode_q != 3'd7) begin
                        if (i_ff_q) begin bus_sel = 3'd7; mem_rd = 1'b1; ar_ld = 1'b1; end
                    end else begin
                        sc_clr = 1'b1;
                        // Priority chain: only the highest-order supported bit acts.
                        if (!i_ff_q) begin
                            if (ir[11])     ac_clr = 1'b1;
                            else if (ir[9]) begin ac_ld = 1'b1; alu_op = 2'd3; end
                            else if (ir[5]) ac_inc = 1'b1;
                            else if (ir[4]) pc_inc = !ac_sign;
                            else if (ir[3]) pc_inc = ac_sign;
                            else if (ir[2]) pc_inc = ac_zero;
                            else if (ir[0]) halt_req = 1'b1;
                        end
                    end
                end
                SCW'(4): begin
                    case (opcode_q)
                        3'd0, 3'd1, 3'd2, 3'd6: begin bus_sel = 3'd7; mem_rd = 1'b1; dr_ld = 1'b1; end
                        3'd3: begin bus_sel = 3'd4; mem_wr = 1'b1; sc_clr = 1'b1; end
                        3'd4: begin bus_sel = 3'd1; pc_ld = 1'b1; sc_clr = 1'b1; end
                        3'd5: begin bus_sel = 3'd2; mem_wr = 1'b1; ar_inc = 1'b1; end
                        default: sc_clr = 1'b1;
                    endcase
                end
                SCW'(5): begin
                    case (opcode_q)
                        3'd0: begin ac_ld = 1'b1; alu_op = 2'd1; sc_clr = 1'b1; end
                        3'd1: begin ac_ld = 1'b1; alu_op = 2'd2; sc_clr = 1'b1; end
                        3'd2: begin ac_ld = 1'b1; alu_op = 2'd0; sc_clr = 1'b1; end
                        3'd5: begin bus_sel = 3'd1; pc_ld = 1'b1; sc_clr = 1'b1; end
                        3'd6: dr_inc = 1'b1;
                        default: sc_clr = 1'b1;
                    endcase
                end
                SCW'(6): begin
                    sc_clr = 1'b1;
                    if (opcode_q == 3'd6) begin
                        bus_sel = 3'd3;
                        mem_wr  = 1'b1;
                        pc_inc  = dr_zero;
                    end
                end
                default: sc_clr = 1'b1;
            endcase
        end
    end

    // Run-state sequencing; opcode and indirect bit are captured at T2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            sc_q     <= '0;
            i_ff_q   <= 1'b0;
            opcode_q <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        sc_q    <= '0;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state_q  <= HALT;
                        sc_q     <= '0;
                        halted_q <= 1'b1;
                    end else begin
                        sc_q <= sc_d;
                    end
                    if (sc_q == SCW'(2)) begin
                        i_ff_q   <= ir[W-1];
                        opcode_q <= ir[W-2:W-4];
                    end
                end
                HALT: begin
                    if (start) begin
                        state_q  <= RUN;
                        sc_q     <= '0;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbc_control_unit.sv
// Scoreboard bench for mbc_control_unit: each stimulus cycle queues its expected outputs,
// and a negedge monitor pops and compares them.
module tb_mbc_control_unit;

    logic        clk = 1'b0;
    logic        reset, start, ac_zero, ac_sign, dr_zero;
    logic [15:0] ir;
    logic        ar_ld, pc_ld, dr_ld, ac_ld, ir_ld, tr_ld;
    logic        ar_inc, pc_inc, dr_inc, ac_inc, ac_clr, mem_rd, mem_wr;
    logic [2:0]  bus_sel;
    logic [1:0]  alu_op;
    logic [2:0]  sc;
    logic        i_ff, halted;

    localparam logic [12:0] AR_LD  = 13'h1000, PC_LD  = 13'h0800, DR_LD  = 13'h0400;
    localparam logic [12:0] AC_LD  = 13'h0200, IR_LD  = 13'h0100;
    localparam logic [12:0] PC_INC = 13'h0020, DR_INC = 13'h0010;
    localparam logic [12:0] AC_CLR = 13'h0004, MEM_RD = 13'h0002, MEM_WR = 13'h0001;
    localparam logic [12:0] NONE   = 13'h0000;

    logic [22:0] expQ[$];
    logic [22:0] observed;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mbc_control_unit #(.W(16), .SCW(3)) dut (
        .clk(clk), .reset(reset), .start(start), .ir(ir),
        .ac_zero(ac_zero), .ac_sign(ac_sign), .dr_zero(dr_zero),
        .ar_ld(ar_ld), .pc_ld(pc_ld), .dr_ld(dr_ld), .ac_ld(ac_ld), .ir_ld(ir_ld), .tr_ld(tr_ld),
        .ar_inc(ar_inc), .pc_inc(pc_inc), .dr_inc(dr_inc), .ac_inc(ac_inc), .ac_clr(ac_clr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .bus_sel(bus_sel), .alu_op(alu_op),
        .sc(sc), .i_ff(i_ff), .halted(halted)
    );

    assign observed = {ar_ld, pc_ld, dr_ld, ac_ld, ir_ld, tr_ld, 1'b0, pc_inc, dr_inc, ac_inc,
                       ac_clr, mem_rd, mem_wr, bus_sel, alu_op, sc, i_ff, halted}
                      | {6'b0, ar_inc, 16'b0};

    function automatic logic [22:0] expVec(input logic [12:0] s, input logic [2:0] b,
                                           input logic [1:0] a, input logic [2:0] t,
                                           input logic f, input logic h);
        return {s, b, a, t, f, h};
    endfunction

    // cond = {dr_zero, ac_zero, ac_sign}
    task automatic applyStimulus(input logic rst, input logic st, input logic [15:0] irv,
                                 input logic [2:0] cond, input logic [22:0] ev);
        #1;
        reset = rst;
        start = st;
        ir = irv;
        {dr_zero, ac_zero, ac_sign} = cond;
        expQ.push_back(ev);
        @(posedge clk);
    endtask

    task automatic fetch(input logic [15:0] irv, input logic iffOld, input logic [2:0] cond);
        applyStimulus(1'b1, 1'b0, irv, cond, expVec(AR_LD, 3'd2, 2'd0, 3'd0, iffOld, 1'b0));
        applyStimulus(1'b1, 1'b0, irv, cond, expVec(MEM_RD | IR_LD | PC_INC, 3'd7, 2'd0, 3'd1, iffOld, 1'b0));
        applyStimulus(1'b1, 1'b0, irv, cond, expVec(AR_LD, 3'd5, 2'd0, 3'd2, iffOld, 1'b0));
    endtask

    task automatic checkOutput(input logic [22:0] ev);
        vectors++;
        if (observed !== ev) begin
            miscompares++;
            $display("[TB] FAIL vec%0d t=%0t: got strobes=%h bus=%0d alu=%0d sc=%0d iff=%b halt=%b, required strobes=%h bus=%0d alu=%0d sc=%0d iff=%b halt=%b",
                     vectors, $time, observed[22:10], observed[9:7], observed[6:5], observed[4:2],
                     observed[1], observed[0], ev[22:10], ev[9:7], ev[6:5], ev[4:2], ev[1], ev[0]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; ir = 16'h0; dr_zero = 1'b0; ac_zero = 1'b0; ac_sign = 1'b0;
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 1'b0, 16'h2010, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0));
        applyStimulus(1'b0, 1'b1, 16'h2010, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b1, 16'h2010, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0));
        // LDA direct
        fetch(16'h2010, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b0, 16'h2010, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h2010, 3'b000, expVec(MEM_RD | DR_LD, 3'd7, 2'd0, 3'd4, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h2010, 3'b000, expVec(AC_LD, 3'd0, 2'd0, 3'd5, 1'b0, 1'b0));
        // BUN indirect
        fetch(16'hC020, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b0, 16'hC020, 3'b000, expVec(MEM_RD | AR_LD, 3'd7, 2'd0, 3'd3, 1'b1, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'hC020, 3'b000, expVec(PC_LD, 3'd1, 2'd0, 3'd4, 1'b1, 1'b0));
        // ISZ with dr_zero=1, then dr_zero=0
        fetch(16'h6030, 1'b1, 3'b100);
        applyStimulus(1'b1, 1'b0, 16'h6030, 3'b100, expVec(NONE, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h6030, 3'b100, expVec(MEM_RD | DR_LD, 3'd7, 2'd0, 3'd4, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h6030, 3'b100, expVec(DR_INC, 3'd0, 2'd0, 3'd5, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h6030, 3'b100, expVec(MEM_WR | PC_INC, 3'd3, 2'd0, 3'd6, 1'b0, 1'b0));
        fetch(16'h6030, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b0, 16'h6030, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h6030, 3'b000, expVec(MEM_RD | DR_LD, 3'd7, 2'd0, 3'd4, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h6030, 3'b000, expVec(DR_INC, 3'd0, 2'd0, 3'd5, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h6030, 3'b000, expVec(MEM_WR, 3'd3, 2'd0, 3'd6, 1'b0, 1'b0));
        // STA direct
        fetch(16'h3005, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b0, 16'h3005, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h3005, 3'b000, expVec(MEM_WR, 3'd4, 2'd0, 3'd4, 1'b0, 1'b0));
        // ADD direct
        fetch(16'h1010, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b0, 16'h1010, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h1010, 3'b000, expVec(MEM_RD | DR_LD, 3'd7, 2'd0, 3'd4, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h1010, 3'b000, expVec(AC_LD, 3'd0, 2'd2, 3'd5, 1'b0, 1'b0));
        // Register-reference: CLA+SZA, SZA, SNA, CMA
        fetch(16'h7804, 1'b0, 3'b010);
        applyStimulus(1'b1, 1'b0, 16'h7804, 3'b010, expVec(AC_CLR, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0));
        fetch(16'h7004, 1'b0, 3'b010);
        applyStimulus(1'b1, 1'b0, 16'h7004, 3'b010, expVec(PC_INC, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0));
        fetch(16'h7008, 1'b0, 3'b001);
        applyStimulus(1'b1, 1'b0, 16'h7008, 3'b001, expVec(PC_INC, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0));
        fetch(16'h7200, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b0, 16'h7200, 3'b000, expVec(AC_LD, 3'd0, 2'd3, 3'd3, 1'b0, 1'b0));
        // HLT, idle in HALT, resume with start
        fetch(16'h7001, 1'b0, 3'b000);
        applyStimulus(1'b1, 1'b0, 16'h7001, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd3, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h7001, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1));
        applyStimulus(1'b1, 1'b0, 16'h7001, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1));
        applyStimulus(1'b1, 1'b1, 16'h7001, 3'b000, expVec(NONE, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1));
        applyStimulus(1'b1, 1'b0, 16'h7001, 3'b000, expVec(AR_LD, 3'd2, 2'd0, 3'd0, 1'b0, 1'b0));
        // Indirect ISZ abandoned by reset at T5
        applyStimulus(1'b1, 1'b0, 16'hE030, 3'b100, expVec(MEM_RD | IR_LD | PC_INC, 3'd7, 2'd0, 3'd1, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'hE030, 3'b100, expVec(AR_LD, 3'd5, 2'd0, 3'd2, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'hE030, 3'b100, expVec(MEM_RD | AR_LD, 3'd7, 2'd0, 3'd3, 1'b1, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'hE030, 3'b100, expVec(MEM_RD | DR_LD, 3'd7, 2'd0, 3'd4, 1'b1, 1'b0));
        applyStimulus(1'b0, 1'b0, 16'hE030, 3'b100, expVec(NONE, 3'd0, 2'd0, 3'd5, 1'b1, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'hE030, 3'b100, expVec(NONE, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'hE030, 3'b100, expVec(NONE, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mbc_control_unit.md
Name: mbc_control_unit

Overview:
- Timing and control sequencer for the 16-bit basic computer. Drives the load, increment and clear strobes of the AR, PC, DR, AC, IR and TR register instances.
- Drives the common-bus select, the memory read/write strobes and the ALU op code.
- Steps a sequence counter through fetch, decode and indirect phases, then executes memory-reference or register-reference instructions.
- Sits between the register file/bus datapath and memory; it holds no data registers itself.

Parameters:
- W, 16, instruction width. IR bit fields assume W=16.
- SCW, 3, sequence counter width; holds T0..T6.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin or resume execution.
- ir  in  W  current IR register output.
- ac_zero  in  1  AC == 0.
- ac_sign  in  1  AC[15].
- dr_zero  in  1  DR == 0.
- ar_ld, pc_ld, dr_ld, ac_ld, ir_ld, tr_ld  out  1 each  register we strobes.
- ar_inc, pc_inc, dr_inc, ac_inc  out  1 each  register inc strobes.
- ac_clr  out  1  AC clear; drives AC register clear input.
- mem_rd  out  1  memory read onto bus.
- mem_wr  out  1  write bus into M[AR].
- bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.
- alu_op  out  2  AC input: 0 PASS_DR, 1 AND, 2 ADD, 3 COM.
- sc  out  SCW  current timing step.
- i_ff  out  1  latched indirect bit.
- halted  out  1  high in HALT state.

Behaviour:
- States: IDLE, RUN, HALT.
  - IDLE -> RUN when start=1.
  - HALT -> RUN when start=1.
  - start is ignored in RUN.
  - Entering RUN always begins at sc=0.
- Reset (reset=0 at a clock edge): state=IDLE, sc=0, i_ff=0, opcode latch=0, halted=0.
  - While reset=0, every strobe, bus_sel and alu_op is forced to 0 combinationally.
  - Reset mid-instruction abandons the instruction; no strobe fires in the reset cycle.
- Strobes are a combinational decode of the registered state, sc, opcode and i_ff. They are 0 outside RUN.
- sc increments each RUN cycle. "SC clr" means sc=0 on the next edge.
- T0: bus_sel=2, ar_ld.
- T1: bus_sel=7, mem_rd, ir_ld, pc_inc.
- T2: bus_sel=5, ar_ld (AR keeps IR[11:0]). Latch i_ff<=ir[15] and opcode<=ir[14:12].
- T3:
  - opcode!=7 and i_ff=1: bus_sel=7, mem_rd, ar_ld.
  - opcode!=7 and i_ff=0: no strobes.
  - opcode==7 and i_ff=0: register-reference (see below), then SC clr.
  - opcode==7 and i_ff=1: I/O, treated as NOP, then SC clr.
- Memory-reference, T4 onward:
  - AND(0), ADD(1), LDA(2):
    - T4: bus_sel=7, mem_rd, dr_ld.
    - T5: ac_ld with alu_op=1, 2 or 0 respectively; SC clr.
  - STA(3):
    - T4: bus_sel=4, mem_wr; SC clr.
  - BUN(4):
    - T4: bus_sel=1, pc_ld; SC clr.
  - BSA(5):
    - T4: bus_sel=2, mem_wr, ar_inc.
    - T5: bus_sel=1, pc_ld; SC clr.
  - ISZ(6):
    - T4: bus_sel=7, mem_rd, dr_ld.
    - T5: dr_inc.
    - T6: bus_sel=3, mem_wr, plus pc_inc if dr_zero=1; SC clr.
- Register-reference at T3: only the highest-order set bit among the supported bits executes.
  - ir[11] CLA: ac_clr.
  - ir[9] CMA: ac_ld, alu_op=3.
  - ir[5] INC: ac_inc.
  - ir[4] SPA: pc_inc if ac_sign=0.
  - ir[3] SNA: pc_inc if ac_sign=1.
  - ir[2] SZA: pc_inc if ac_zero=1.
  - ir[0] HLT: next state HALT, sc=0, halted=1.
  - Unsupported or no bits set: NOP.
- At most one bus_sel source is active per cycle. ld and inc are never asserted together on the same register.
- sc never exceeds 6. An illegal sc value in RUN forces SC clr with no strobes.

Test Plan:
- Release reset, pulse start, ir=16'h2010 (LDA 0x010 direct) -> T0 ar_ld/bus 2; T1 ir_ld, pc_inc, mem_rd; T2 ar_ld/bus 5, i_ff=0; T4 dr_ld; T5 ac_ld with alu_op=0; sc returns to 0 after 6 cycles.
- ir=16'hC020 (BUN indirect) -> T3 mem_rd+ar_ld on bus 7; T4 pc_ld on bus 1; next cycle sc=0.
- ir=16'h6030 (ISZ), dr_zero=1 at T6 -> T6 mem_wr on bus 3 with pc_inc. Repeat with dr_zero=0 -> no pc_inc.
- ir=16'h7804 (CLA+SZA), ac_zero=1 -> at T3 only ac_clr fires, pc_inc=0. Then ir=16'h7004, ac_zero=1 -> pc_inc at T3.
- ir=16'h7001 (HLT) -> halted=1, all strobes 0, start ignored in cycles without start. Pulse start -> RUN at sc=0 with T0 strobes.
- Assert reset=0 during ISZ T5 -> same cycle all strobes 0. Next edge: IDLE, sc=0, i_ff=0. No dr_inc or mem_wr observed.
